vector_exec_unit: RTL and testbench

- Multi-cycle, strip-mined successor to the single-cycle vector coprocessor.
- Holds an NREGS x VLMAX register file. Executes one vector instruction over a programmable vector length vl, processing LANES elements per cycle.
- Adds an issue/done handshake, a scalar-broadcast operand, tail-undisturbed writes, a sum reduction, and a host element access port.
- Sits beside the scalar core: the core issues instructions and polls done/vec_zero/red_result.

---
 rtl/vec_pkg.sv | 41 ++++
 rtl/vec_lane_alu.sv | 34 +++
 rtl/vector_exec_unit.sv | 171 +++++++++++++++++
 tb/tb_vector_exec_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared types for the strip-mined vector execution unit: opcodes, FSM states
// and the instruction fields latched at issue.
package vec_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_OR     = 4'd3,
        OP_NOR    = 4'd4,
        OP_SL     = 4'd5,
        OP_SR     = 4'd6,
        OP_SLT    = 4'd7,
        OP_REDSUM = 4'd8
    } alu_op_e;

    // Opcodes 9..15 are reserved: they complete without touching the register file.
    localparam logic [3:0] OP_RSVD_FIRST = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0] op;
        logic [4:0] shamt;
        logic       use_sign;
        logic       use_scalar;
    } instr_t;

    function automatic logic op_writes(input logic [3:0] op);
        return op <= OP_SLT;
    endfunction

    function automatic logic op_reserved(input logic [3:0] op);
        return op >= OP_RSVD_FIRST;
    endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// Combinational single-element ALU; one copy per lane.
module vec_lane_alu
    import vec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      op,
    input  logic [4:0]      shamt,
    input  logic            use_sign,
    output logic [XLEN-1:0] result
);

    logic lt;

    always_comb begin
        lt = use_sign ? ($signed(a) < $signed(b)) : (a < b);
        result = '0;
        case (op)
            OP_ADD: result = a + b;
            OP_SUB: result = a - b;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_NOR: result = ~(a | b);
            // Shifts operate on b (rt or the broadcast scalar); a is ignored.
            OP_SL:  result = b << shamt;
            OP_SR:  result = use_sign ? XLEN'($signed(b) >>> shamt) : (b >> shamt);
            OP_SLT: result = {{(XLEN-1){1'b0}}, lt};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/vector_exec_unit.sv
// Multi-cycle vector unit: executes one instruction over vl elements, LANES per
// beat, with tail-undisturbed writes, a sum reduction and a host element port.
module vector_exec_unit
    import vec_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int LANES = 4,
    parameter int VLMAX = 16,
    parameter int NREGS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [3:0]                 aluOp,
    input  logic [$clog2(NREGS)-1:0]   vec_addr_rd,
    input  logic [$clog2(NREGS)-1:0]   vec_addr_rs,
    input  logic [$clog2(NREGS)-1:0]   vec_addr_rt,
    input  logic [$clog2(VLMAX+1)-1:0] vl,
    input  logic [4:0]                 shamt,
    input  logic                       useSign,
    input  logic                       use_scalar,
    input  logic [XLEN-1:0]            scalar_val,
    output logic                       done,
    output logic                       vec_zero,
    output logic [XLEN-1:0]            red_result,
    input  logic                       host_we,
    input  logic [$clog2(NREGS)-1:0]   host_reg,
    input  logic [$clog2(VLMAX)-1:0]   host_elem,
    input  logic [XLEN-1:0]            host_wdata,
    output logic [XLEN-1:0]            host_rdata
);

    localparam int AW     = $clog2(NREGS);
    localparam int EL_W   = $clog2(VLMAX);
    localparam int VL_W   = $clog2(VLMAX+1);
    localparam int NBEATS = VLMAX / LANES;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    logic [XLEN-1:0] rf [NREGS][VLMAX];

    state_e            state;
    instr_t            cfg;
    logic [AW-1:0]     rd_q, rs_q, rt_q;
    logic [VL_W-1:0]   vl_q;
    logic [XLEN-1:0]   scalar_q;
    logic [BEAT_W-1:0] beat;
    logic              zero_acc;
    logic [XLEN-1:0]   sum_acc;

    logic [VL_W-1:0]   vl_clamped;
    logic [VL_W-1:0]   vl_m1;
    logic [VL_W-1:0]   last_beat;
    logic              is_last;

    logic [LANES-1:0]            active;
    logic [LANES-1:0][EL_W-1:0]  el;
    logic [LANES-1:0][XLEN-1:0]  a_v, b_v, res;

    logic [XLEN-1:0] beat_sum, sum_next;
    logic            beat_zero, zero_next;

    assign vl_clamped  = (vl > VL_W'(VLMAX)) ? VL_W'(VLMAX) : vl;
    // EXEC is only entered with vl_q >= 1, so vl_q-1 never underflows there.
    assign vl_m1       = vl_q - 1'b1;
    assign last_beat   = vl_m1 / VL_W'(LANES);
    assign is_last     = (VL_W'(beat) == last_beat);

    assign issue_ready = (state == S_IDLE);
    assign done        = (state == S_DONE);
    assign host_rdata  = rf[host_reg][host_elem];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [VL_W-1:0] e;
        assign e         = VL_W'(beat) * VL_W'(LANES) + VL_W'(i);
        assign active[i] = (e < vl_q);
        assign el[i]     = e[EL_W-1:0];
        assign a_v[i]    = rf[rs_q][el[i]];
        assign b_v[i]    = cfg.use_scalar ? scalar_q : rf[rt_q][el[i]];

        vec_lane_alu #(.XLEN(XLEN)) u_alu (
            .a        (a_v[i]),
            .b        (b_v[i]),
            .op       (cfg.op),
            .shamt    (cfg.shamt),
            .use_sign (cfg.use_sign),
            .result   (res[i])
        );
    end

    always_comb begin
        beat_sum  = '0;
        beat_zero = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            if (active[i]) begin
                beat_sum = beat_sum + a_v[i];
                if (res[i] != '0) beat_zero = 1'b0;
            end
        end
        if (op_reserved(cfg.op)) beat_zero = 1'b1;
        sum_next  = sum_acc + beat_sum;
        zero_next = zero_acc & beat_zero;
    end

    // vec_zero/red_result are updated on the edge entering DONE so they are
    // already valid while done is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cfg        <= '0;
            rd_q       <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            vl_q       <= '0;
            scalar_q   <= '0;
            beat       <= '0;
            zero_acc   <= 1'b1;
            sum_acc    <= '0;
            vec_zero   <= 1'b0;
            red_result <= '0;
            for (int r = 0; r < NREGS; r++)
                for (int e = 0; e < VLMAX; e++)
                    rf[r][e] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (host_we) rf[host_reg][host_elem] <= host_wdata;
                    if (issue_valid) begin
                        cfg      <= '{op: aluOp, shamt: shamt, use_sign: useSign,
                                      use_scalar: use_scalar};
                        rd_q     <= vec_addr_rd;
                        rs_q     <= vec_addr_rs;
                        rt_q     <= vec_addr_rt;
                        vl_q     <= vl_clamped;
                        scalar_q <= scalar_val;
                        beat     <= '0;
                        zero_acc <= 1'b1;
                        sum_acc  <= '0;
                        if (vl_clamped == '0) begin
                            state    <= S_DONE;
                            vec_zero <= 1'b1;
                            if (aluOp == OP_REDSUM) red_result <= '0;
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    for (int i = 0; i < LANES; i++)
                        if (active[i] && op_writes(cfg.op))
                            rf[rd_q][el[i]] <= res[i];
                    zero_acc <= zero_next;
                    sum_acc  <= sum_next;
                    if (is_last) begin
                        state <= S_DONE;
                        if (cfg.op == OP_REDSUM) begin
                            red_result <= sum_next;
                            vec_zero   <= (sum_next == '0);
                        end else begin
                            vec_zero <= zero_next;
                        end
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_exec_unit.sv
// Directed bench for vector_exec_unit: hand-computed expectations per scenario.
module tb_vector_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  aluOp;
    logic [2:0]  vec_addr_rd, vec_addr_rs, vec_addr_rt;
    logic [4:0]  vl;
    logic [4:0]  shamt;
    logic        useSign, use_scalar;
    logic [31:0] scalar_val;
    logic        done, vec_zero;
    logic [31:0] red_result;
    logic        host_we;
    logic [2:0]  host_reg;
    logic [3:0]  host_elem;
    logic [31:0] host_wdata, host_rdata;

    int checks = 0;
    int errors = 0;

    vector_exec_unit dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .aluOp(aluOp), .vec_addr_rd(vec_addr_rd), .vec_addr_rs(vec_addr_rs),
        .vec_addr_rt(vec_addr_rt), .vl(vl), .shamt(shamt), .useSign(useSign),
        .use_scalar(use_scalar), .scalar_val(scalar_val), .done(done),
        .vec_zero(vec_zero), .red_result(red_result), .host_we(host_we),
        .host_reg(host_reg), .host_elem(host_elem), .host_wdata(host_wdata),
        .host_rdata(host_rdata)
    );

    always #5 clk = ~clk;

    task automatic host_write(input int r, input int e, input logic [31:0] d);
        host_we = 1'b1; host_reg = 3'(r); host_elem = 4'(e); host_wdata = d;
        @(posedge clk); #1;
        host_we = 1'b0;
    endtask

    task automatic host_read(input int r, input int e, output logic [31:0] d);
        host_reg = 3'(r); host_elem = 4'(e);
        #1 d = host_rdata;
    endtask

    // Issues one instruction and returns the number of edges after acceptance
    // until done is seen (capped at 100), then lets the unit return to IDLE.
    task automatic issue(input logic [3:0] op, input int rd, input int rs, input int rt,
                         input int vl_i, input int sh, input logic sg, input logic usc,
                         input logic [31:0] sc, output int cyc);
        aluOp = op; vec_addr_rd = 3'(rd); vec_addr_rs = 3'(rs); vec_addr_rt = 3'(rt);
        vl = 5'(vl_i); shamt = 5'(sh); useSign = sg; use_scalar = usc; scalar_val = sc;
        issue_valid = 1'b1;
        @(posedge clk); #1;
        issue_valid = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", issue_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (vec_zero !== 1'b0) begin errors++; $display("FAIL reset_vec_zero got %b exp 0", vec_zero); end
        checks++; if (red_result !== 32'd0) begin errors++; $display("FAIL reset_red got %h exp 0", red_result); end
        host_read(1, 3, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_rf got %h exp 0", d); end
    endtask

    task automatic test_add();
        int cyc;
        logic [31:0] d;
        for (int e = 0; e < 16; e++) begin
            host_write(1, e, 32'(10 * (e + 1)));
            host_write(2, e, 32'(e + 1));
        end
        issue(4'd0, 3, 1, 2, 4, 0, 1'b0, 1'b0, 32'd0, cyc);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL add_latency got %0d exp 1", cyc); end
        for (int e = 0; e < 16; e++) begin
            host_read(3, e, d);
            checks++;
            if (d !== ((e < 4) ? 32'(11 * (e + 1)) : 32'd0)) begin
                errors++; $display("FAIL add_v3[%0d] got %h exp %h", e, d, (e < 4) ? 32'(11 * (e + 1)) : 32'd0);
            end
        end
    endtask

    task automatic test_sub_scalar();
        int low, done_at;
        logic [31:0] d;
        aluOp = 4'd1; vec_addr_rd = 3'd4; vec_addr_rs = 3'd1; vec_addr_rt = 3'd2;
        vl = 5'd16; shamt = 5'd0; useSign = 1'b0; use_scalar = 1'b1; scalar_val = 32'd5;
        issue_valid = 1'b1;
        @(posedge clk); #1;
        issue_valid = 1'b0;
        low = 0; done_at = -1;
        while (issue_ready !== 1'b1 && low < 100) begin
            low++;
            if (done === 1'b1) done_at = low;
            @(posedge clk); #1;
        end
        checks++; if (low !== 5) begin errors++; $display("FAIL sub_ready_low got %0d exp 5", low); end
        checks++; if (done_at !== 5) begin errors++; $display("FAIL sub_done_cycle got %0d exp 5", done_at); end
        for (int e = 0; e < 16; e++) begin
            host_read(4, e, d);
            checks++;
            if (d !== 32'(10 * (e + 1) - 5)) begin
                errors++; $display("FAIL sub_v4[%0d] got %h exp %h", e, d, 32'(10 * (e + 1) - 5));
            end
        end
    endtask

    task automatic test_shift_tail();
        int cyc;
        logic [31:0] d;
        for (int e = 0; e < 16; e++) host_write(5, e, 32'hDEAD);
        issue(4'd5, 5, 0, 2, 6, 1, 1'b0, 1'b0, 32'd0, cyc);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL sl_latency got %0d exp 2", cyc); end
        for (int e = 0; e < 16; e++) begin
            host_read(5, e, d);
            checks++;
            if (d !== ((e < 6) ? 32'(2 * (e + 1)) : 32'hDEAD)) begin
                errors++; $display("FAIL sl_v5[%0d] got %h exp %h", e, d, (e < 6) ? 32'(2 * (e + 1)) : 32'hDEAD);
            end
        end
    endtask

    task automatic test_zero_flag();
        int cyc;
        logic [31:0] d;
        issue(4'd1, 6, 1, 1, 16, 0, 1'b0, 1'b0, 32'd0, cyc);
        checks++; if (vec_zero !== 1'b1) begin errors++; $display("FAIL zero_sub got %b exp 1", vec_zero); end
        // vl=20 exceeds VLMAX and must clamp to 16 (4 beats).
        issue(4'd0, 7, 1, 2, 20, 0, 1'b0, 1'b0, 32'd0, cyc);
        checks++; if (vec_zero !== 1'b0) begin errors++; $display("FAIL zero_add got %b exp 0", vec_zero); end
        checks++; if (cyc !== 4) begin errors++; $display("FAIL clamp_latency got %0d exp 4", cyc); end
        host_read(7, 15, d);
        checks++; if (d !== 32'd176) begin errors++; $display("FAIL clamp_v7[15] got %h exp %h", d, 32'd176); end
        issue(4'd0, 3, 1, 2, 0, 0, 1'b0, 1'b0, 32'd0, cyc);
        checks++; if (cyc !== 0) begin errors++; $display("FAIL vl0_latency got %0d exp 0", cyc); end
        checks++; if (vec_zero !== 1'b1) begin errors++; $display("FAIL vl0_zero got %b exp 1", vec_zero); end
        host_read(3, 0, d);
        checks++; if (d !== 32'd11) begin errors++; $display("FAIL vl0_nowrite got %h exp %h", d, 32'd11); end
    endtask

    task automatic test_redsum_shift();
        int cyc;
        logic [31:0] d;
        issue(4'd8, 3, 2, 0, 5, 0, 1'b0, 1'b0, 32'd0, cyc);
        checks++; if (red_result !== 32'd15) begin errors++; $display("FAIL redsum got %0d exp 15", red_result); end
        checks++; if (vec_zero !== 1'b0) begin errors++; $display("FAIL redsum_zero got %b exp 0", vec_zero); end
        checks++; if (cyc !== 2) begin errors++; $display("FAIL redsum_latency got %0d exp 2", cyc); end
        host_read(3, 1, d);
        checks++; if (d !== 32'd22) begin errors++; $display("FAIL redsum_nowrite got %h exp %h", d, 32'd22); end
        host_write(0, 0, 32'hFFFF_FFF8);
        issue(4'd6, 6, 1, 0, 1, 1, 1'b1, 1'b0, 32'd0, cyc);
        host_read(6, 0, d);
        checks++; if (d !== 32'hFFFF_FFFC) begin errors++; $display("FAIL sra got %h exp FFFFFFFC", d); end
        issue(4'd6, 6, 1, 0, 1, 1, 1'b0, 1'b0, 32'd0, cyc);
        host_read(6, 0, d);
        checks++; if (d !== 32'h7FFF_FFFC) begin errors++; $display("FAIL srl got %h exp 7FFFFFFC", d); end
        checks++; if (red_result !== 32'd15) begin errors++; $display("FAIL red_hold got %0d exp 15", red_result); end
        issue(4'd7, 6, 0, 0, 1, 0, 1'b1, 1'b1, 32'd1, cyc);
        host_read(6, 0, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL slt_signed got %h exp 1", d); end
        issue(4'd7, 6, 0, 0, 1, 0, 1'b0, 1'b1, 32'd1, cyc);
        host_read(6, 0, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL slt_unsigned got %h exp 0", d); end
        // Reserved opcode: no write, still completes with vec_zero=1.
        issue(4'd12, 6, 1, 2, 4, 0, 1'b0, 1'b0, 32'd0, cyc);
        host_read(6, 0, d);
        checks++; if (d !== 32'd0 || vec_zero !== 1'b1 || cyc !== 1) begin
            errors++; $display("FAIL reserved got d=%h z=%b cyc=%0d exp 0 1 1", d, vec_zero, cyc);
        end
    endtask

    task automatic test_reset_mid();
        int nz, cyc;
        logic [31:0] d;
        aluOp = 4'd1; vec_addr_rd = 3'd4; vec_addr_rs = 3'd1; vec_addr_rt = 3'd2;
        vl = 5'd16; shamt = 5'd0; useSign = 1'b0; use_scalar = 1'b0;
        issue_valid = 1'b1;
        @(posedge clk); #1;
        issue_valid = 1'b0;
        host_we = 1'b1; host_reg = 3'd0; host_elem = 4'd0; host_wdata = 32'h1234;
        @(posedge clk); #1;
        host_we = 1'b0;
        @(posedge clk); #1;
        host_read(0, 0, d);
        checks++; if (d !== 32'hFFFF_FFF8) begin errors++; $display("FAIL host_exec_ignored got %h exp FFFFFFF8", d); end
        host_read(4, 0, d);
        checks++; if (d !== 32'd9) begin errors++; $display("FAIL mid_beat0 got %h exp 9", d); end
        rst = 1'b0;
        #1;
        checks++; if (issue_ready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL mid_reset_ctl got ready=%b done=%b exp 1 0", issue_ready, done);
        end
        nz = 0;
        for (int r = 0; r < 8; r++)
            for (int e = 0; e < 16; e++) begin
                host_read(r, e, d);
                if (d !== 32'd0) nz++;
            end
        checks++; if (nz !== 0) begin errors++; $display("FAIL mid_reset_rf got %0d nonzero exp 0", nz); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        host_write(1, 0, 32'd7);
        issue(4'd0, 3, 1, 2, 4, 0, 1'b0, 1'b0, 32'd0, cyc);
        host_read(3, 0, d);
        checks++; if (d !== 32'd7 || cyc !== 1) begin errors++; $display("FAIL post_reset_add got %h cyc %0d exp 7 1", d, cyc); end
    endtask

    initial begin
        rst = 1'b0; issue_valid = 1'b0; aluOp = '0; vec_addr_rd = '0; vec_addr_rs = '0;
        vec_addr_rt = '0; vl = '0; shamt = '0; useSign = 1'b0; use_scalar = 1'b0;
        scalar_val = '0; host_we = 1'b0; host_reg = '0; host_elem = '0; host_wdata = '0;
        #12 rst = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_add();
        test_sub_scalar();
        test_shift_tail();
        test_zero_flag();
        test_redsum_shift();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
